alu_uart_interface: RTL and testbench

- Front end that drives the ALU from a UART link, replacing the bench stimulus.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents the operands and opcode to the ALU and captures the ALU result.
- Sends the result back as one byte to the UART transmitter, with a start/done handshake.

---
 rtl/alu_uart_interface.sv | 113 +++++++++++
 tb/tb_alu_uart_interface.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// UART front end for the ALU: gathers A, B and opcode bytes,
// latches the ALU result and hands it to the transmitter.
module alu_uart_interface #(
  parameter int NB_BYTE     = 8,
  parameter int NB_DATA_IN  = 5,
  parameter int NB_DATA_OUT = 6,
  parameter int NB_OPERADOR = 6
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_BYTE-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  input  logic [NB_DATA_OUT-1:0] i_resultado,
  input  logic                   i_tx_done,
  output logic [NB_DATA_IN-1:0]  o_dato_a,
  output logic [NB_DATA_IN-1:0]  o_dato_b,
  output logic [NB_OPERADOR-1:0] o_operador,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_drop
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    CALC,
    SEND,
    WAIT_TX
  } state_t;

  state_t state, state_nx;

  logic ld_a;
  logic ld_b;
  logic ld_op;
  logic ld_res;

  logic [NB_BYTE-1:0] res_ext;
  logic               unused_rx_hi;

  assign res_ext = {{(NB_BYTE-NB_DATA_OUT){i_resultado[NB_DATA_OUT-1]}},
                    i_resultado};

  assign unused_rx_hi = ^i_rx_data[NB_BYTE-1:NB_OPERADOR];

  always_comb begin
    state_nx   = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_op      = 1'b0;
    ld_res     = 1'b0;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    o_drop     = 1'b0;
    unique case (state)
      WAIT_A: begin
        if (i_rx_done) begin
          ld_a     = 1'b1;
          state_nx = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          ld_b     = 1'b1;
          state_nx = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          ld_op    = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        o_busy   = 1'b1;
        o_drop   = i_rx_done;
        ld_res   = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        o_busy     = 1'b1;
        o_drop     = i_rx_done;
        o_tx_start = 1'b1;
        state_nx   = WAIT_TX;
      end
      WAIT_TX: begin
        o_busy = 1'b1;
        o_drop = i_rx_done;
        if (i_tx_done) state_nx = WAIT_A;
      end
      default: state_nx = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= WAIT_A;
      o_dato_a   <= '0;
      o_dato_b   <= '0;
      o_operador <= '0;
      o_tx_data  <= '0;
    end else begin
      state <= state_nx;
      if (ld_a)   o_dato_a   <= i_rx_data[NB_DATA_IN-1:0];
      if (ld_b)   o_dato_b   <= i_rx_data[NB_DATA_IN-1:0];
      if (ld_op)  o_operador <= i_rx_data[NB_OPERADOR-1:0];
      if (ld_res) o_tx_data  <= res_ext;
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: a stand-in ALU, byte-level
// stimulus and a tx_start-driven scoreboard.
module tb_alu_uart_interface;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_done = 1'b0;
  logic [5:0] i_resultado;
  logic       i_tx_done = 1'b0;
  logic [4:0] o_dato_a;
  logic [4:0] o_dato_b;
  logic [5:0] o_operador;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_drop;

  int n_tests  = 0;
  int n_fail   = 0;
  int drop_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       prev_start = 1'b0;

  alu_uart_interface #(
    .NB_BYTE(8), .NB_DATA_IN(5), .NB_DATA_OUT(6), .NB_OPERADOR(6)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .i_resultado(i_resultado),
    .i_tx_done  (i_tx_done),
    .o_dato_a   (o_dato_a),
    .o_dato_b   (o_dato_b),
    .o_operador (o_operador),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_busy     (o_busy),
    .o_drop     (o_drop)
  );

  always #5 i_clock = ~i_clock;

  // Stand-in ALU: operands treated as signed 5-bit values.
  logic signed [5:0] sa, sb, r;
  always_comb begin
    sa = {o_dato_a[4], o_dato_a};
    sb = {o_dato_b[4], o_dato_b};
    r  = '0;
    case (o_operador)
      6'h20:   r = sa + sb;
      6'h22:   r = sa - sb;
      6'h24:   r = sa & sb;
      6'h25:   r = sa | sb;
      6'h26:   r = sa ^ sb;
      6'h27:   r = ~(sa | sb);
      6'h03:   r = sa >>> o_dato_b;
      6'h02:   r = sa >> o_dato_b;
      default: r = '0;
    endcase
    i_resultado = r;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_start must match the oldest queued byte.
  always @(negedge i_clock) begin
    if (i_reset) begin
      if (o_drop) drop_cnt++;
      if (o_tx_start) begin
        check("tx_start_back_to_back", {31'd0, prev_start}, 0);
        if (exp_q.size() == 0) begin
          check("spurious_tx_start", 1, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_data", {24'd0, o_tx_data}, {24'd0, exp_b});
        end
      end
      prev_start = o_tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clock); #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clock); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge i_clock); #1;
    i_tx_done = 1'b1;
    @(posedge i_clock); #1;
    i_tx_done = 1'b0;
  endtask

  // mode 0: plain, 1: extra byte in WAIT_TX,
  // 2: rx_done with tx_done, 3: stray tx_done in WAIT_B
  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] op, input logic [7:0] exp,
                     input int mode);
    int d0;
    d0 = drop_cnt;
    exp_q.push_back(exp);
    send_byte(a);
    if (mode == 3) pulse_tx_done();
    send_byte(b);
    send_byte(op);
    @(negedge i_clock);
    check("calc_busy", {31'd0, o_busy}, 1);
    check("calc_no_start", {31'd0, o_tx_start}, 0);
    @(negedge i_clock);
    check("latency_start", {31'd0, o_tx_start}, 1);
    check("dato_a", {27'd0, o_dato_a}, {27'd0, a[4:0]});
    check("dato_b", {27'd0, o_dato_b}, {27'd0, b[4:0]});
    check("operador", {26'd0, o_operador}, {26'd0, op[5:0]});
    @(negedge i_clock);
    check("wait_tx_start_low", {31'd0, o_tx_start}, 0);
    check("wait_tx_busy", {31'd0, o_busy}, 1);
    if (mode == 1) begin
      @(posedge i_clock); #1;
      i_rx_data = 8'h55;
      i_rx_done = 1'b1;
      @(negedge i_clock);
      check("drop_pulse", {31'd0, o_drop}, 1);
      @(posedge i_clock); #1;
      i_rx_done = 1'b0;
      @(negedge i_clock);
      check("drop_one_cycle", {31'd0, o_drop}, 0);
      check("drop_keeps_a", {27'd0, o_dato_a}, {27'd0, a[4:0]});
      check("drop_keeps_busy", {31'd0, o_busy}, 1);
      pulse_tx_done();
    end else if (mode == 2) begin
      @(posedge i_clock); #1;
      i_rx_data = 8'h55;
      i_rx_done = 1'b1;
      i_tx_done = 1'b1;
      @(negedge i_clock);
      check("simul_drop", {31'd0, o_drop}, 1);
      @(posedge i_clock); #1;
      i_rx_done = 1'b0;
      i_tx_done = 1'b0;
    end else begin
      pulse_tx_done();
    end
    @(negedge i_clock); #1;
    check("idle_busy", {31'd0, o_busy}, 0);
    check("tx_data_hold", {24'd0, o_tx_data}, {24'd0, exp});
    check("drop_count", drop_cnt - d0, (mode == 1 || mode == 2) ? 1 : 0);
  endtask

  initial begin
    #12;
    check("rst_dato_a", {27'd0, o_dato_a}, 0);
    check("rst_dato_b", {27'd0, o_dato_b}, 0);
    check("rst_operador", {26'd0, o_operador}, 0);
    check("rst_tx_data", {24'd0, o_tx_data}, 0);
    check("rst_ctrl", {29'd0, o_tx_start, o_busy, o_drop}, 0);
    @(posedge i_clock); #1;
    i_reset = 1'b1;

    txn(8'h0A, 8'h0A, 8'h20, 8'h14, 0);
    txn(8'h06, 8'h07, 8'h22, 8'hFF, 0);
    txn(8'h16, 8'h03, 8'h03, 8'hFE, 0);
    txn(8'h15, 8'h07, 8'h24, 8'h05, 0);
    txn(8'hEA, 8'h0A, 8'h20, 8'h14, 0);
    txn(8'h01, 8'h02, 8'h25, 8'h03, 1);
    txn(8'h0F, 8'h05, 8'h26, 8'h0A, 2);
    txn(8'h0A, 8'h0A, 8'h20, 8'h14, 3);

    send_byte(8'h0B);
    send_byte(8'h0C);
    #3;
    i_reset = 1'b0;
    #1;
    check("mid_rst_dato_a", {27'd0, o_dato_a}, 0);
    check("mid_rst_dato_b", {27'd0, o_dato_b}, 0);
    check("mid_rst_tx_data", {24'd0, o_tx_data}, 0);
    check("mid_rst_ctrl", {29'd0, o_tx_start, o_busy, o_drop}, 0);
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clock);
    txn(8'h06, 8'h07, 8'h22, 8'hFF, 0);

    txn(8'h0A, 8'h0A, 8'h20, 8'h14, 0);
    txn(8'h06, 8'h07, 8'h22, 8'hFF, 0);
    txn(8'h15, 8'h07, 8'h24, 8'h05, 0);
    txn(8'h01, 8'h02, 8'h25, 8'h03, 0);
    txn(8'h0F, 8'h05, 8'h26, 8'h0A, 0);
    txn(8'h0F, 8'h01, 8'h27, 8'hF0, 0);
    txn(8'h16, 8'h03, 8'h03, 8'hFE, 0);
    txn(8'h10, 8'h01, 8'h02, 8'h18, 0);

    repeat (5) @(negedge i_clock);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
